// File: rtl/tdm_demux2.sv
// Two-channel TDM receive demultiplexer: routes alternating ch0/ch1 samples to
// registered outputs, tracks frame alignment and counts sync errors.
module tdm_demux2 #(
   parameter int W     = 8,
   parameter int ERR_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [W-1:0]     in_data,
   input  logic             in_sof,
   output logic [W-1:0]     out0,
   output logic             out0_valid,
   output logic [W-1:0]     out1,
   output logic             out1_valid,
   output logic             pair_valid,
   output logic             sel,
   output logic             locked,
   output logic             sync_err,
   output logic [ERR_W-1:0] err_count
);

   typedef enum logic [1:0] {
      HUNT = 2'd0,
      EXP1 = 2'd1,
      EXP0 = 2'd2
   } state_t;

   state_t             state_q;
   logic [W-1:0]       out0_q, out1_q;
   logic               out0_valid_q, out1_valid_q, pair_valid_q;
   logic               locked_q, sync_err_q;
   logic [ERR_W-1:0]   err_count_q;
   logic               err_hit_d;

   // An alignment violation is a marker where ch1 was due, or no marker where ch0 was due.
   always_comb begin
      err_hit_d = 1'b0;
      if (in_valid) begin
         err_hit_d = ((state_q == EXP1) &&  in_sof) ||
                     ((state_q == EXP0) && !in_sof);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= HUNT;
         out0_q       <= '0;
         out1_q       <= '0;
         out0_valid_q <= 1'b0;
         out1_valid_q <= 1'b0;
         pair_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         sync_err_q   <= 1'b0;
         err_count_q  <= '0;
      end else begin
         out0_valid_q <= 1'b0;
         out1_valid_q <= 1'b0;
         pair_valid_q <= 1'b0;
         sync_err_q   <= err_hit_d;
         if (err_hit_d && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_q <= err_count_q + ERR_W'(1);
         end
         if (in_valid) begin
            case (state_q)
               HUNT: begin
                  if (in_sof) begin
                     out0_q       <= in_data;
                     out0_valid_q <= 1'b1;
                     locked_q     <= 1'b1;
                     state_q      <= EXP1;
                  end
               end
               EXP1: begin
                  if (!in_sof) begin
                     out1_q       <= in_data;
                     out1_valid_q <= 1'b1;
                     pair_valid_q <= 1'b1;
                     state_q      <= EXP0;
                  end else begin
                     // Missing ch1: treat this marker as a fresh frame start.
                     out0_q       <= in_data;
                     out0_valid_q <= 1'b1;
                  end
               end
               EXP0: begin
                  if (in_sof) begin
                     out0_q       <= in_data;
                     out0_valid_q <= 1'b1;
                     state_q      <= EXP1;
                  end else begin
                     locked_q <= 1'b0;
                     state_q  <= HUNT;
                  end
               end
               default: state_q <= HUNT;
            endcase
         end
      end
   end

   assign sel        = (state_q == EXP1);
   assign out0       = out0_q;
   assign out1       = out1_q;
   assign out0_valid = out0_valid_q;
   assign out1_valid = out1_valid_q;
   assign pair_valid = pair_valid_q;
   assign locked     = locked_q;
   assign sync_err   = sync_err_q;
   assign err_count  = err_count_q;

endmodule

// File: tb/tb_tdm_demux2.sv
// Randomized bench for tdm_demux2 checked against a frame-position reference model;
// a second instance with ERR_W=2 exercises counter saturation.
module tb_tdm_demux2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_sof;

   logic [7:0] out0, out1;
   logic       out0_valid, out1_valid, pair_valid, sel, locked, sync_err;
   logic [7:0] err_count;

   logic [7:0] s_out0, s_out1;
   logic       s_out0_valid, s_out1_valid, s_pair_valid, s_sel, s_locked, s_sync_err;
   logic [1:0] s_err_count;

   int n_cmp = 0;
   int n_bad = 0;
   int n_txn = 0;

   // Reference model: samples received so far in the current frame (0 = hunting).
   int         m_frame_pos = 0;
   logic [7:0] m_out0 = 0, m_out1 = 0;
   logic       m_locked = 0;
   int         m_errs = 0;
   logic       m_p0, m_p1, m_se;

   always #5 clk = ~clk;

   tdm_demux2 #(.W(8), .ERR_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
      .out0(out0), .out0_valid(out0_valid), .out1(out1), .out1_valid(out1_valid),
      .pair_valid(pair_valid), .sel(sel), .locked(locked), .sync_err(sync_err),
      .err_count(err_count)
   );

   tdm_demux2 #(.W(8), .ERR_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
      .out0(s_out0), .out0_valid(s_out0_valid), .out1(s_out1), .out1_valid(s_out1_valid),
      .pair_valid(s_pair_valid), .sel(s_sel), .locked(s_locked), .sync_err(s_sync_err),
      .err_count(s_err_count)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s txn=%0d got=0x%0h expected=0x%0h", tag, n_txn, got, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, compare every output 1 time unit after the edge.
   task automatic cyc(input logic rst, input logic v, input logic sof, input logic [7:0] d);
      rst_n    = !rst;
      in_valid = v;
      in_sof   = sof;
      in_data  = d;
      @(posedge clk);
      #1;
      n_txn++;
      m_p0 = 0; m_p1 = 0; m_se = 0;
      if (rst) begin
         m_frame_pos = 0; m_out0 = 0; m_out1 = 0; m_locked = 0; m_errs = 0;
      end else if (v) begin
         if (m_frame_pos == 0) begin
            if (sof) begin m_out0 = d; m_p0 = 1; m_frame_pos = 1; m_locked = 1; end
         end else if (m_frame_pos == 1) begin
            if (!sof) begin m_out1 = d; m_p1 = 1; m_frame_pos = 2; end
            else begin m_se = 1; m_out0 = d; m_p0 = 1; end
         end else begin
            if (sof) begin m_out0 = d; m_p0 = 1; m_frame_pos = 1; end
            else begin m_se = 1; m_frame_pos = 0; m_locked = 0; end
         end
      end
      if (m_se) m_errs++;
      $display("txn %0d rst=%b v=%b sof=%b d=0x%02h", n_txn, rst, v, sof, d);
      check_eq("out0",       out0,       m_out0);
      check_eq("out1",       out1,       m_out1);
      check_eq("out0_valid", out0_valid, m_p0);
      check_eq("out1_valid", out1_valid, m_p1);
      check_eq("pair_valid", pair_valid, m_p1);
      check_eq("sel",        sel,        (m_frame_pos == 1));
      check_eq("locked",     locked,     m_locked);
      check_eq("sync_err",   sync_err,   m_se);
      check_eq("err_count",  err_count,  (m_errs > 255) ? 255 : m_errs);
      check_eq("sat_count",  s_err_count, (m_errs > 3) ? 3 : m_errs);
      check_eq("sat_out0",   s_out0,     m_out0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
      // Reset then alignment
      cyc(1, 1, 1, 8'hFF); cyc(1, 0, 0, 8'h00);
      cyc(0, 1, 1, 8'hA1); cyc(0, 1, 0, 8'hB1); cyc(0, 1, 1, 8'hA2); cyc(0, 1, 0, 8'hB2);
      check_eq("align_out0", out0, 8'hA2);
      check_eq("align_out1", out1, 8'hB2);
      // Missing marker -> hunt, discard, then hunt discards
      cyc(0, 1, 0, 8'h03);
      check_eq("mm_out0_kept", out0, 8'hA2);
      cyc(0, 1, 0, 8'h11); cyc(0, 1, 0, 8'h22);
      cyc(0, 1, 1, 8'h33); cyc(0, 1, 0, 8'h44);
      check_eq("hunt_out0", out0, 8'h33);
      check_eq("hunt_out1", out1, 8'h44);
      // Missing ch1 while locked
      cyc(0, 1, 1, 8'h10); cyc(0, 1, 1, 8'h20);
      check_eq("mc1_sync_err", sync_err, 1'b1);
      cyc(0, 1, 0, 8'h30);
      check_eq("mc1_out0", out0, 8'h20);
      check_eq("mc1_out1", out1, 8'h30);
      // Missing marker then relock, then push the small counter past saturation
      cyc(0, 1, 1, 8'h01); cyc(0, 1, 0, 8'h02); cyc(0, 1, 0, 8'h03);
      check_eq("mm_locked", locked, 1'b0);
      cyc(0, 1, 1, 8'h04);
      check_eq("relock", locked, 1'b1);
      for (int i = 0; i < 5; i++) cyc(0, 1, 1, 8'(8'h70 + i));
      check_eq("sat_stop", s_err_count, 2'd3);
      // Mid-frame reset
      cyc(0, 1, 1, 8'h55); cyc(1, 1, 0, 8'h99); cyc(0, 1, 0, 8'h66);
      check_eq("mfr_out1", out1, 8'h00);
      // Random traffic with gaps and occasional reset
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 9) < 4) ? ~sel : sel, 8'($urandom));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
